// File: rtl/vx_wb_arbiter.sv
// Register-file write-port arbiter: merges the memory/writeback pipeline and a
// long-latency unit, with a starvation counter that periodically favours the long source.
module vx_wb_arbiter #(
  parameter  int NUM_THREADS = 4,
  parameter  int NUM_WARPS   = 8,
  parameter  int MAX_WAIT    = 3,
  localparam int WW          = $clog2(NUM_WARPS),
  localparam int DW          = NUM_THREADS * 32
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   p_valid,
  output logic                   p_ready,
  input  logic [NUM_THREADS-1:0] p_mask,
  input  logic [4:0]             p_rd,
  input  logic [1:0]             p_wb,
  input  logic [WW-1:0]          p_warp,
  input  logic [DW-1:0]          p_data,

  input  logic                   l_valid,
  output logic                   l_ready,
  input  logic [NUM_THREADS-1:0] l_mask,
  input  logic [4:0]             l_rd,
  input  logic [1:0]             l_wb,
  input  logic [WW-1:0]          l_warp,
  input  logic [DW-1:0]          l_data,

  output logic                   freeze_out,

  output logic                   wb_valid,
  output logic [NUM_THREADS-1:0] wb_mask,
  output logic [4:0]             wb_rd,
  output logic [1:0]             wb_wb,
  output logic [WW-1:0]          wb_warp,
  output logic [DW-1:0]          wb_data,

  output logic                   busy_long
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    PIPE_PRI = 1'b0,
    LONG_PRI = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                   p_grant, l_grant;

  logic                   wb_valid_q, wb_valid_d;
  logic [NUM_THREADS-1:0] wb_mask_q, wb_mask_d;
  logic [4:0]             wb_rd_q, wb_rd_d;
  logic [1:0]             wb_wb_q, wb_wb_d;
  logic [WW-1:0]          wb_warp_q, wb_warp_d;
  logic [DW-1:0]          wb_data_q, wb_data_d;

  // A lone requester always wins; contention is resolved by the priority state.
  always_comb begin
    p_grant = 1'b0;
    l_grant = 1'b0;
    if (p_valid && l_valid) begin
      if (state_q == LONG_PRI) begin
        l_grant = 1'b1;
      end else begin
        p_grant = 1'b1;
      end
    end else begin
      p_grant = p_valid;
      l_grant = l_valid;
    end
  end

  assign p_ready    = p_grant;
  assign l_ready    = l_grant;
  assign freeze_out = p_valid & ~p_grant;
  assign busy_long  = (state_q == LONG_PRI);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;

    if (!l_valid || l_grant) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WCW'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end

    // LONG_PRI always lasts a single cycle: either the long source is granted or it vanished.
    case (state_q)
      PIPE_PRI: begin
        if (l_valid && !l_grant && (wait_cnt_q == WCW'(MAX_WAIT - 1))) begin
          state_d = LONG_PRI;
        end
      end
      LONG_PRI: begin
        if (l_grant || !l_valid) begin
          state_d = PIPE_PRI;
        end
      end
      default: state_d = PIPE_PRI;
    endcase
  end

  // Write fields hold their previous value when nothing is granted; only the mask is cleared.
  always_comb begin
    wb_valid_d = p_grant | l_grant;
    wb_mask_d  = '0;
    wb_rd_d    = wb_rd_q;
    wb_wb_d    = wb_wb_q;
    wb_warp_d  = wb_warp_q;
    wb_data_d  = wb_data_q;
    if (p_grant) begin
      wb_mask_d = p_mask;
      wb_rd_d   = p_rd;
      wb_wb_d   = p_wb;
      wb_warp_d = p_warp;
      wb_data_d = p_data;
    end else if (l_grant) begin
      wb_mask_d = l_mask;
      wb_rd_d   = l_rd;
      wb_wb_d   = l_wb;
      wb_warp_d = l_warp;
      wb_data_d = l_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= PIPE_PRI;
      wait_cnt_q <= '0;
      wb_valid_q <= 1'b0;
      wb_mask_q  <= '0;
      wb_rd_q    <= '0;
      wb_wb_q    <= '0;
      wb_warp_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_mask_q  <= wb_mask_d;
      wb_rd_q    <= wb_rd_d;
      wb_wb_q    <= wb_wb_d;
      wb_warp_q  <= wb_warp_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_mask  = wb_mask_q;
  assign wb_rd    = wb_rd_q;
  assign wb_wb    = wb_wb_q;
  assign wb_warp  = wb_warp_q;
  assign wb_data  = wb_data_q;

  a_one_grant: assert property (@(posedge clk) disable iff (!reset) !(p_grant && l_grant));

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Scoreboard bench for vx_wb_arbiter: directed vectors push expected writes,
// a negedge monitor pops and compares them against the registered write port.
module tb_vx_wb_arbiter;

  localparam int NT = 4;
  localparam int WW = 3;
  localparam int DW = NT * 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          p_valid, p_ready, l_valid, l_ready;
  logic [NT-1:0] p_mask, l_mask, wb_mask;
  logic [4:0]    p_rd, l_rd, wb_rd;
  logic [1:0]    p_wb, l_wb, wb_wb;
  logic [WW-1:0] p_warp, l_warp, wb_warp;
  logic [DW-1:0] p_data, l_data, wb_data;
  logic          freeze_out, wb_valid, busy_long;

  always #5 clk = ~clk;

  vx_wb_arbiter #(.NUM_THREADS(NT), .NUM_WARPS(8), .MAX_WAIT(3)) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_ready(p_ready), .p_mask(p_mask), .p_rd(p_rd),
    .p_wb(p_wb), .p_warp(p_warp), .p_data(p_data),
    .l_valid(l_valid), .l_ready(l_ready), .l_mask(l_mask), .l_rd(l_rd),
    .l_wb(l_wb), .l_warp(l_warp), .l_data(l_data),
    .freeze_out(freeze_out),
    .wb_valid(wb_valid), .wb_mask(wb_mask), .wb_rd(wb_rd), .wb_wb(wb_wb),
    .wb_warp(wb_warp), .wb_data(wb_data), .busy_long(busy_long)
  );

  typedef struct {
    logic          v;
    logic [NT-1:0] m;
    logic [4:0]    rd;
    logic [1:0]    wb;
    logic [WW-1:0] warp;
    logic [DW-1:0] d;
    int            due;
  } req_t;

  req_t exp_q[$];
  req_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  bit   proto_en = 1'b1;

  logic [4:0]    last_rd;
  logic [1:0]    last_wb;
  logic [WW-1:0] last_warp;
  logic [DW-1:0] last_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters must hold valid and fields until accepted; deliberately relaxed for the drop scenarios.
  a_p_hold: assert property (@(posedge clk) disable iff (!reset || !proto_en)
    (p_valid && !p_ready) |=> (p_valid && $stable({p_mask, p_rd, p_wb, p_warp, p_data})))
    else $error("[TB] pipeline requester changed before acceptance");
  a_l_hold: assert property (@(posedge clk) disable iff (!reset || !proto_en)
    (l_valid && !l_ready) |=> (l_valid && $stable({l_mask, l_rd, l_wb, l_warp, l_data})))
    else $error("[TB] long requester changed before acceptance");

  function automatic req_t mk(input logic [4:0] rd, input logic [NT-1:0] m,
                              input logic [1:0] wb, input logic [WW-1:0] warp);
    req_t r;
    r.v = 1'b1; r.m = m; r.rd = rd; r.wb = wb; r.warp = warp; r.due = 0;
    for (int i = 0; i < NT; i++) r.d[32*i +: 32] = {8'hA0 + 8'(rd), 8'(i), 16'h5A00 | 16'(rd)};
    return r;
  endfunction

  function automatic req_t none();
    req_t r;
    r.v = 1'b0; r.m = '0; r.rd = '0; r.wb = '0; r.warp = '0; r.d = '0; r.due = 0;
    return r;
  endfunction

  function automatic req_t pr(input logic [4:0] rd);
    return mk(rd, 4'hF, 2'd1, 3'd1);
  endfunction

  function automatic req_t lr(input logic [4:0] rd);
    return mk(rd, 4'b0110, 2'd3, 3'd5);
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input req_t p, input req_t l);
    p_valid = p.v; p_mask = p.m; p_rd = p.rd; p_wb = p.wb; p_warp = p.warp; p_data = p.d;
    l_valid = l.v; l_mask = l.m; l_rd = l.rd; l_wb = l.wb; l_warp = l.warp; l_data = l.d;
  endtask

  // Called just after a rising edge; one call is one arbitration cycle.
  task automatic applyStimulus(input req_t p, input req_t l, input bit epr, input bit elr,
                               input bit ebusy);
    req_t e;
    drive(p, l);
    if (epr) begin e = p; e.due = cyc + 1; exp_q.push_back(e); end
    if (elr) begin e = l; e.due = cyc + 1; exp_q.push_back(e); end
    @(negedge clk);
    checkOutput("p_ready", p_ready, epr);
    checkOutput("l_ready", l_ready, elr);
    checkOutput("freeze_out", freeze_out, p.v & ~epr);
    checkOutput("busy_long", busy_long, ebusy);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every falling edge, either a granted write is due or the port must be idle and holding.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        checkOutput("wb_valid_in_reset", wb_valid, 0);
        last_rd = '0; last_wb = '0; last_warp = '0; last_data = '0;
      end else if (wb_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("[TB] FAIL unexpected_write: got wb_valid=1 rd=%0d, expected no write (cycle %0d)",
                   wb_rd, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("wb_cycle", cyc, mon_e.due);
          checkOutput("wb_mask", wb_mask, mon_e.m);
          checkOutput("wb_rd", wb_rd, mon_e.rd);
          checkOutput("wb_wb", wb_wb, mon_e.wb);
          checkOutput("wb_warp", wb_warp, mon_e.warp);
          checkOutput("wb_data", wb_data, mon_e.d);
          last_rd = mon_e.rd; last_wb = mon_e.wb; last_warp = mon_e.warp; last_data = mon_e.d;
        end
      end else begin
        checkOutput("idle_mask", wb_mask, 0);
        checkOutput("hold_rd", wb_rd, last_rd);
        checkOutput("hold_wb", wb_wb, last_wb);
        checkOutput("hold_warp", wb_warp, last_warp);
        checkOutput("hold_data", wb_data, last_data);
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          n_checks++;
          n_fails++;
          $display("[TB] FAIL missing_write: got wb_valid=0, expected write rd=%0d (cycle %0d)",
                   exp_q[0].rd, cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    req_t s1p, s2l;
    drive(none(), none());

    repeat (2) @(negedge clk);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_wb_mask", wb_mask, 0);
    checkOutput("rst_wb_rd", wb_rd, 0);
    checkOutput("rst_wb_data", wb_data, 0);
    checkOutput("rst_busy_long", busy_long, 0);
    p_valid = 1'b1;
    #1;
    checkOutput("rst_p_ready", p_ready, 1);
    checkOutput("rst_freeze", freeze_out, 0);
    p_valid = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] pipeline only");
    s1p = mk(5'd5, 4'hF, 2'd0, 3'd0);
    s1p.d = {4{32'h11}};
    applyStimulus(s1p, none(), 1, 0, 0);
    applyStimulus(none(), none(), 0, 0, 0);

    $display("[TB] long only");
    s2l = mk(5'd7, 4'b1010, 2'd2, 3'd2);
    applyStimulus(none(), s2l, 0, 1, 0);
    applyStimulus(none(), none(), 0, 0, 0);

    $display("[TB] both valid, starvation period 4");
    applyStimulus(pr(1), lr(20), 1, 0, 0);
    applyStimulus(pr(2), lr(20), 1, 0, 0);
    applyStimulus(pr(3), lr(20), 1, 0, 0);
    applyStimulus(pr(4), lr(20), 0, 1, 1);
    applyStimulus(pr(4), lr(21), 1, 0, 0);
    applyStimulus(pr(5), lr(21), 1, 0, 0);
    applyStimulus(pr(6), lr(21), 1, 0, 0);
    applyStimulus(pr(7), lr(21), 0, 1, 1);
    applyStimulus(pr(7), none(), 1, 0, 0);
    applyStimulus(none(), none(), 0, 0, 0);

    $display("[TB] alternating single requesters, including an empty mask");
    applyStimulus(pr(8), none(), 1, 0, 0);
    applyStimulus(none(), lr(9), 0, 1, 0);
    applyStimulus(mk(5'd10, 4'h0, 2'd2, 3'd6), none(), 1, 0, 0);
    applyStimulus(none(), lr(11), 0, 1, 0);
    applyStimulus(none(), none(), 0, 0, 0);

    proto_en = 1'b0;
    $display("[TB] long request withdrawn during long priority");
    applyStimulus(pr(13), lr(22), 1, 0, 0);
    applyStimulus(pr(14), lr(22), 1, 0, 0);
    applyStimulus(pr(15), lr(22), 1, 0, 0);
    applyStimulus(pr(16), none(), 1, 0, 1);
    applyStimulus(pr(17), none(), 1, 0, 0);
    applyStimulus(none(), none(), 0, 0, 0);

    $display("[TB] reset during long priority");
    applyStimulus(pr(1), lr(23), 1, 0, 0);
    applyStimulus(pr(2), lr(23), 1, 0, 0);
    applyStimulus(pr(3), lr(23), 1, 0, 0);
    drive(pr(4), lr(23));
    @(negedge clk);
    checkOutput("pre_rst_busy_long", busy_long, 1);
    checkOutput("pre_rst_l_ready", l_ready, 1);
    checkOutput("pre_rst_freeze", freeze_out, 1);
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("mid_rst_wb_valid", wb_valid, 0);
    checkOutput("mid_rst_wb_rd", wb_rd, 0);
    checkOutput("mid_rst_wb_mask", wb_mask, 0);
    checkOutput("mid_rst_busy_long", busy_long, 0);
    checkOutput("mid_rst_p_ready", p_ready, 1);
    checkOutput("mid_rst_l_ready", l_ready, 0);
    checkOutput("mid_rst_freeze", freeze_out, 0);
    drive(none(), none());
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(pr(12), lr(24), 1, 0, 0);
    applyStimulus(none(), lr(24), 0, 1, 0);
    applyStimulus(none(), none(), 0, 0, 0);
    proto_en = 1'b1;

    repeat (3) applyStimulus(none(), none(), 0, 0, 0);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
